cnt_min_hour: RTL
=================

Name: cnt_min_hour

Overview:
- Time-of-day stage directly downstream of the seconds counter.
- Consumes the one-cycle minute-increment enable `inc_m` and keeps minutes (0..59) and hours (0..23).
- Provides a button-driven time-set state machine.
- Emits a one-cycle day-rollover enable `inc_d` for a future calendar stage.
- Everything is clocked on the divided 1 Hz clock.

Parameters:
- MIN_MOD, 60, minute modulus; minute counts 0..MIN_MOD-1; legal range 2..64.
- HOUR_MOD, 24, hour modulus; hour counts 0..HOUR_MOD-1; legal range 2..32.

Ports:
- clk_div  input  1  divided (1 Hz) clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- inc_m  input  1  minute-increment enable, synchronous to clk_div; one increment per sampled high cycle.
- btn_mode  input  1  debounced, synchronised mode button (level).
- btn_up  input  1  debounced, synchronised up button (level).
- minute  output  6  current minute.
- hour  output  5  current hour.
- mode  output  2  FSM state: 0 RUN, 1 SET_HOUR, 2 SET_MIN.
- inc_d  output  1  one-cycle day-rollover enable.

Behaviour:
- Clock and reset:
  - Single clock clk_div.
  - Reset is asynchronous assert, active-low (rst_n).
  - On reset: minute=0, hour=0, mode=RUN, inc_d=0, both button-history flops=1.
  - History flops reset to 1 so a button held through reset release produces no press.
- Press detection:
  - press_x = btn_x & ~btn_x_q, where btn_x_q is btn_x registered.
  - A press sampled at edge k takes effect in the registers updated at edge k.
  - Holding a button yields exactly one press; a new press needs a low cycle first.
- FSM:
  - RUN --press_mode--> SET_HOUR --press_mode--> SET_MIN --press_mode--> RUN.
  - Encoding 3 is unreachable; if ever entered, it returns to RUN on the next edge with counters untouched.
- RUN:
  - inc_m=1: minute+1.
  - If minute==MIN_MOD-1: minute=0 and hour+1.
  - If additionally hour==HOUR_MOD-1: hour=0 and inc_d=1 for that cycle only.
  - inc_d is registered; it is high in the same cycle minute/hour read 0/0.
  - inc_m=0: hold; inc_d=0.
  - press_up in RUN is ignored.
- SET_HOUR:
  - press_up: hour+1, wrapping HOUR_MOD-1 -> 0.
  - No effect on minute; no inc_d.
- SET_MIN:
  - press_up: minute+1, wrapping MIN_MOD-1 -> 0.
  - No carry into hour; no inc_d.
- In both SET states inc_m is ignored: time is frozen and missed increments are not queued.
- Simultaneous events:
  - press_mode with inc_m in RUN: the increment (and any carry or inc_d) is applied and mode goes to SET_HOUR on the same edge.
  - press_mode with press_up in a SET state: mode advances; press_up is discarded.
- inc_d is never asserted outside RUN. It is a pulse, never held two consecutive cycles.
- Reset mid-operation (any state, any pending press): immediate return to reset values; no pulse emitted.
- Width rules: counters are compared for equality against MOD-1 before increment, so no overflow past the modulus.

Decomposition:
- Package clock_pkg holds:
  - mode typedef/localparams: RUN=2'd0, SET_HOUR=2'd1, SET_MIN=2'd2.
  - MIN_W=6 and HOUR_W=5.
  - Default moduli 60/24.
- One natural sub-module, rise_det (input clk_div, rst_n, level; output press; history flop resets to 1), instantiated for btn_mode and btn_up.
- The FSM and the counters stay in cnt_min_hour.

Test Plan:
- Reset/idle:
  - Assert rst_n=0 mid-count with mode=SET_MIN and btn_up held high.
  - Release with btn_up still high.
  - Required: minute=0, hour=0, mode=0, inc_d=0; no increment until btn_up goes low then high.
- Minute and hour carry:
  - Drive 60 single-cycle inc_m pulses from 00:00.
  - Required: minute counts 1..59, then reads 0 with hour=1 on the 60th pulse's edge; inc_d stays 0.
- Day rollover:
  - Preset 23:59 via the SET path, return to RUN, pulse inc_m once.
  - Required: next edge minute=0, hour=0, inc_d=1 for exactly one cycle, 0 on the following cycle.
- Set wrap:
  - Enter SET_HOUR at hour=22 and give 3 up-presses → hour 23, 0, 1; minute unchanged.
  - In SET_MIN at minute=58 give 3 up-presses → 59, 0, 1; hour unchanged; inc_d never 1.
- Freeze and priority:
  - In SET_HOUR, drive 5 inc_m pulses → counters unchanged.
  - Press mode and up on the same edge in SET_HOUR → mode=2, hour unchanged.
  - In RUN at 00:59, press mode on the inc_m edge → hour=1, minute=0, mode=1.
- Mode cycle: 3 mode presses from RUN → mode sequence 1, 2, 0; held button counts once.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared widths, default moduli and mode encoding for the time-of-day stage.
package clock_pkg;

    localparam int unsigned MIN_W        = 6;
    localparam int unsigned HOUR_W       = 5;
    localparam int unsigned MIN_MOD_DEF  = 60;
    localparam int unsigned HOUR_MOD_DEF = 24;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_e;

endpackage

// File: rtl/rise_det.sv
// Rising-edge press detector for a synchronised, debounced button level.
// History resets high so a button held through reset release is not a press.
module rise_det (
    input  logic clk_div,
    input  logic rst_n,
    input  logic level,
    output logic press
);

    logic r_level_q;

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= 1'b1;
        end else begin
            r_level_q <= level;
        end
    end

    assign press = level & ~r_level_q;

endmodule

// File: rtl/cnt_min_hour.sv
// Minute/hour counter with button-driven time-set FSM and day-rollover pulse.
module cnt_min_hour
    import clock_pkg::*;
#(
    parameter int unsigned MIN_MOD  = MIN_MOD_DEF,
    parameter int unsigned HOUR_MOD = HOUR_MOD_DEF
) (
    input  logic              clk_div,
    input  logic              rst_n,
    input  logic              inc_m,
    input  logic              btn_mode,
    input  logic              btn_up,
    output logic [MIN_W-1:0]  minute,
    output logic [HOUR_W-1:0] hour,
    output logic [1:0]        mode,
    output logic              inc_d
);

    localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(MIN_MOD - 1);
    localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_MOD - 1);

    mode_e             r_mode;
    mode_e             w_mode_nxt;
    logic [MIN_W-1:0]  r_minute;
    logic [MIN_W-1:0]  w_minute_nxt;
    logic [HOUR_W-1:0] r_hour;
    logic [HOUR_W-1:0] w_hour_nxt;
    logic              r_inc_d;
    logic              w_inc_d_nxt;
    logic              w_press_mode;
    logic              w_press_up;
    logic              w_min_last;
    logic              w_hour_last;

    rise_det u_rise_mode (
        .clk_div (clk_div),
        .rst_n   (rst_n),
        .level   (btn_mode),
        .press   (w_press_mode)
    );

    rise_det u_rise_up (
        .clk_div (clk_div),
        .rst_n   (rst_n),
        .level   (btn_up),
        .press   (w_press_up)
    );

    assign w_min_last  = (r_minute == MIN_MAX);
    assign w_hour_last = (r_hour == HOUR_MAX);

    // Mode state register.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    // Counter and rollover-pulse registers.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            r_minute <= '0;
            r_hour   <= '0;
            r_inc_d  <= 1'b0;
        end else begin
            r_minute <= w_minute_nxt;
            r_hour   <= w_hour_nxt;
            r_inc_d  <= w_inc_d_nxt;
        end
    end

    // Next state; in SET states a mode press wins over an up press.
    always_comb begin
        w_mode_nxt   = r_mode;
        w_minute_nxt = r_minute;
        w_hour_nxt   = r_hour;
        w_inc_d_nxt  = 1'b0;
        case (r_mode)
            RUN: begin
                if (inc_m) begin
                    if (w_min_last) begin
                        w_minute_nxt = '0;
                        if (w_hour_last) begin
                            w_hour_nxt  = '0;
                            w_inc_d_nxt = 1'b1;
                        end else begin
                            w_hour_nxt = r_hour + HOUR_W'(1);
                        end
                    end else begin
                        w_minute_nxt = r_minute + MIN_W'(1);
                    end
                end
                if (w_press_mode) begin
                    w_mode_nxt = SET_HOUR;
                end
            end
            SET_HOUR: begin
                if (w_press_mode) begin
                    w_mode_nxt = SET_MIN;
                end else if (w_press_up) begin
                    w_hour_nxt = w_hour_last ? '0 : r_hour + HOUR_W'(1);
                end
            end
            SET_MIN: begin
                if (w_press_mode) begin
                    w_mode_nxt = RUN;
                end else if (w_press_up) begin
                    w_minute_nxt = w_min_last ? '0 : r_minute + MIN_W'(1);
                end
            end
            default: begin
                w_mode_nxt = RUN;
            end
        endcase
    end

    assign minute = r_minute;
    assign hour   = r_hour;
    assign mode   = r_mode;
    assign inc_d  = r_inc_d;

endmodule
